ctrl_bubble_pipe: RTL and testbench

Parametrised control-word pipeline for the multi-cycle/pipelined datapath. It carries the decoder's packed control word (MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, RegDst, ALUSrc, or any wider successor) through STAGES pipeline registers. Hazard-driven bubble insertion (NOP control word) happens at stage 0. The block also supports per-stage flush, global freeze, per-stage valid tracking and a saturating bubble counter. It sits between the control unit and the ID/EX, EX/MEM, MEM/WB register boundaries, and the hazard unit drives it.

---
 rtl/ctrl_bubble_pipe.sv | 86 ++++++++
 tb/tb_ctrl_bubble_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_bubble_pipe.sv
// Control-word pipeline: carries the decoder control word through STAGES registers,
// with bubble insertion at stage 0, per-stage flush, global freeze and a saturating bubble counter.
module ctrl_bubble_pipe #(
   parameter int                 CTRL_W   = 8,
   parameter int                 STAGES   = 3,
   parameter logic [CTRL_W-1:0]  NOP_WORD = {CTRL_W{1'b0}},
   parameter int                 CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CTRL_W-1:0]          ctrl_in,
   input  logic                       in_valid,
   input  logic                       bubble,
   input  logic                       freeze,
   input  logic [STAGES-1:0]          flush,
   input  logic                       cnt_clr,
   output logic [STAGES*CTRL_W-1:0]   ctrl_out,
   output logic [STAGES-1:0]          valid_out,
   output logic [CNT_W-1:0]           bubble_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic bubble_ev;
   assign bubble_ev = bubble & in_valid & ~freeze & ~flush[0];

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stg
         logic [CTRL_W-1:0] word_p;
         logic              vld_p;

         if (k == 0) begin : g_head
            // stage 0: bubble or idle input loads the NOP word
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  word_p <= NOP_WORD;
                  vld_p  <= 1'b0;
               end else if (flush[0]) begin
                  word_p <= NOP_WORD;
                  vld_p  <= 1'b0;
               end else if (!freeze) begin
                  if (bubble || !in_valid) begin
                     word_p <= NOP_WORD;
                     vld_p  <= 1'b0;
                  end else begin
                     word_p <= ctrl_in;
                     vld_p  <= 1'b1;
                  end
               end
            end
         end else begin : g_body
            // stage k>0: true shift from the previous stage's old value
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  word_p <= NOP_WORD;
                  vld_p  <= 1'b0;
               end else if (flush[k]) begin
                  word_p <= NOP_WORD;
                  vld_p  <= 1'b0;
               end else if (!freeze) begin
                  word_p <= g_stg[k-1].word_p;
                  vld_p  <= g_stg[k-1].vld_p;
               end
            end
         end

         assign ctrl_out[k*CTRL_W +: CTRL_W] = word_p;
         assign valid_out[k]                 = vld_p;
      end
   endgenerate

   // clear wins over a same-cycle bubble event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (cnt_clr) begin
         bubble_cnt <= '0;
      end else if (bubble_ev) begin
         bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Directed bench for ctrl_bubble_pipe (STAGES=3, CTRL_W=8, NOP=0x00, CNT_W=4) with a scoreboard queue.
module tb_ctrl_bubble_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ctrl_in;
   logic        in_valid;
   logic        bubble;
   logic        freeze;
   logic [2:0]  flush;
   logic        cnt_clr;
   logic [23:0] ctrl_out;
   logic [2:0]  valid_out;
   logic [3:0]  bubble_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [23:0] c;
      logic [2:0]  v;
      logic [3:0]  n;
   } exp_t;

   exp_t sb[$];

   ctrl_bubble_pipe #(
      .CTRL_W(8), .STAGES(3), .NOP_WORD(8'h00), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .in_valid(in_valid),
      .bubble(bubble), .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
      .ctrl_out(ctrl_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [23:0] c, input logic [2:0] v, input logic [3:0] n);
      exp_t e;
      e.tag = tag;
      e.c   = c;
      e.v   = v;
      e.n   = n;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL sb_empty got=%0d required=1", sb.size());
         return;
      end
      e = sb.pop_front();
      total++;
      assert (ctrl_out === e.c) else begin
         bad++;
         $error("FAIL %s ctrl_out got=%h required=%h", e.tag, ctrl_out, e.c);
      end
      total++;
      assert (valid_out === e.v) else begin
         bad++;
         $error("FAIL %s valid_out got=%b required=%b", e.tag, valid_out, e.v);
      end
      total++;
      assert (bubble_cnt === e.n) else begin
         bad++;
         $error("FAIL %s bubble_cnt got=%0d required=%0d", e.tag, bubble_cnt, e.n);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] c, input logic iv, input logic b,
                       input logic fz, input logic [2:0] fl, input logic clr,
                       input logic [23:0] ec, input logic [2:0] ev, input logic [3:0] en);
      @(negedge clk);
      ctrl_in  = c;
      in_valid = iv;
      bubble   = b;
      freeze   = fz;
      flush    = fl;
      cnt_clr  = clr;
      push_exp(tag, ec, ev, en);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      rst_n    = 1'b0;
      ctrl_in  = 8'hFF;
      in_valid = 1'b1;
      bubble   = 1'b0;
      freeze   = 1'b0;
      flush    = 3'b000;
      cnt_clr  = 1'b0;

      // reset held: inputs must not be captured
      for (int i = 0; i < 3; i++) begin
         push_exp("rst_hold", 24'h000000, 3'b000, 4'd0);
         @(posedge clk);
         #1;
         check_pop();
      end
      @(negedge clk);
      rst_n = 1'b1;
      push_exp("rst_release", 24'h0000FF, 3'b001, 4'd0);
      @(posedge clk);
      #1;
      check_pop();

      // streaming
      step("stream1", 8'h4C, 1, 0, 0, 3'b000, 0, 24'hFF4C00 >> 0 & 24'h0000FF | 24'h00FF4C & 24'hFFFF00 | 24'h00004C, 3'b011, 4'd0);
      step("stream2", 8'h68, 1, 0, 0, 3'b000, 0, 24'hFF4C68, 3'b111, 4'd0);
      step("stream3", 8'hC2, 1, 0, 0, 3'b000, 0, 24'h4C68C2, 3'b111, 4'd0);

      // freeze + flush of middle stage
      step("frz_flush", 8'h11, 1, 0, 1, 3'b010, 0, 24'h4C00C2, 3'b101, 4'd0);
      step("frz_bubble", 8'h22, 1, 1, 1, 3'b000, 0, 24'h4C00C2, 3'b101, 4'd0);
      step("unfreeze", 8'h33, 1, 0, 0, 3'b000, 0, 24'h00C233, 3'b011, 4'd0);

      // load-use bubble and its travel downstream
      step("bubble", 8'h68, 1, 1, 0, 3'b000, 0, 24'hC23300, 3'b110, 4'd1);
      step("after_bub", 8'h68, 1, 0, 0, 3'b000, 0, 24'h330068, 3'b101, 4'd1);
      step("idle", 8'h99, 0, 0, 0, 3'b000, 0, 24'h006800, 3'b010, 4'd1);
      step("bub_flush0", 8'h99, 1, 1, 0, 3'b001, 0, 24'h680000, 3'b100, 4'd1);
      step("bub_novalid", 8'h99, 0, 1, 0, 3'b000, 0, 24'h000000, 3'b000, 4'd1);

      // saturation then clear
      for (int i = 0; i < 20; i++) begin
         step("sat", 8'h77, 1, 1, 0, 3'b000, 0, 24'h000000, 3'b000,
              (i + 2 > 15) ? 4'd15 : 4'(i + 2));
      end
      step("clr_prio", 8'h77, 1, 1, 0, 3'b000, 1, 24'h000000, 3'b000, 4'd0);
      step("cnt_resume", 8'h77, 1, 1, 0, 3'b000, 0, 24'h000000, 3'b000, 4'd1);

      // async reset mid-flight
      step("fill1", 8'h4C, 1, 0, 0, 3'b000, 0, 24'h00004C, 3'b001, 4'd1);
      step("fill2", 8'h68, 1, 0, 0, 3'b000, 0, 24'h004C68, 3'b011, 4'd1);
      step("fill3", 8'hC2, 1, 0, 0, 3'b000, 0, 24'h4C68C2, 3'b111, 4'd1);
      #2;
      rst_n = 1'b0;
      #1;
      push_exp("async_rst", 24'h000000, 3'b000, 4'd0);
      check_pop();
      @(negedge clk);
      in_valid = 1'b0;
      push_exp("async_hold", 24'h000000, 3'b000, 4'd0);
      @(posedge clk);
      #1;
      check_pop();
      @(negedge clk);
      rst_n = 1'b1;
      push_exp("post_rst_idle", 24'h000000, 3'b000, 4'd0);
      @(posedge clk);
      #1;
      check_pop();
      step("post_rst_new", 8'h5A, 1, 0, 0, 3'b000, 0, 24'h00005A, 3'b001, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
